// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and bubble counter.
// Define PIPE_STAGE_SKID_EN to add a skid register (registered in_ready, two beats held).
module pipe_stage_reg #(
    parameter int                CTRL_W   = 20,
    parameter int                DATA_W   = 128,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Skid only ever holds a beat while main is full, so in_ready is a pure flop output.
    assign in_ready  = !skid_valid;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= NOP_CTRL;
            main_data  <= '0;
            skid_ctrl  <= NOP_CTRL;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            if (in_fire) begin
                main_valid <= 1'b1;
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
            end
        end else if (out_fire) begin
            if (skid_valid) begin
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end
    end
`else
    // Without a skid register the stage accepts whenever main drains this cycle.
    assign in_ready  = !main_valid || out_ready;
    assign occupancy = {1'b0, main_valid};

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_ctrl  <= NOP_CTRL;
            main_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
        end else if (in_fire) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
        end else if (out_fire) begin
            main_valid <= 1'b0;
        end
    end
`endif

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : NOP_CTRL;
    assign out_data  = main_valid ? main_data : '0;

    // Counts cycles where downstream was ready but got nothing; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (out_ready && !main_valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
